uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `N_REQ` byte producers. Each requester hands over one byte through a valid/ready handshake into a private holding register. The arbiter grants the transmitter to one pending requester, pulses its start input, holds the byte stable for the whole frame, and releases the grant on the transmitter's done pulse. It sits between the host-side producers and the `Tx` module's `Tx_start`/`Tx_din`/`Tx_done` pins. A cycle-count watchdog recovers from a transmitter that never reports done.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `W_DATA`, 8: byte width; must match the transmitter's `W_DATA`.
- `W_TMO`, 24: width of the watchdog limit and counter.
- `W_ID`, `$clog2(N_REQ)` (localparam): grant index width.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  N_REQ  per-requester byte-valid.
- `req_data`  in  N_REQ*W_DATA  requester i's byte in slice [i*W_DATA +: W_DATA].
- `req_ready`  out  N_REQ  per-requester holding register empty.
- `tmo_limit`  in  W_TMO  watchdog limit in clk cycles; 0 disables the watchdog.
- `tx_start`  out  1  to `Tx_start`; one-cycle pulse.
- `tx_din`  out  W_DATA  to `Tx_din`; held stable for the entire frame.
- `tx_done`  in  1  from `Tx_done`.
- `grant_id`  out  W_ID  index of the requester currently or last granted.
- `busy`  out  1  FSM not in IDLE.
- `sent`  out  1  one-cycle pulse: granted byte completed normally.
- `tmo_err`  out  1  one-cycle pulse: granted byte aborted by the watchdog.

## Operation
- Holding registers: `hold[i]` and `pending[i]`, one pair per requester.
  - `req_ready[i] = !pending[i]`, decoded from flops only, with no combinational path from inputs.
  - On `req_valid[i] && req_ready[i]`, capture the byte into `hold[i]` and set `pending[i]`.
  - `pending[i]` clears only in RELEASE while `grant_id == i`. Capture and clear of the same `i` cannot coincide because `ready` is low while pending.
- Round-robin selection:
  - The search starts at `last_grant+1` and wraps modulo `N_REQ`.
  - The first pending index wins.
  - `last_grant` resets to `N_REQ-1`, so requester 0 has first priority after reset.
  - `last_grant` updates in RELEASE.
- FSM states:
  - IDLE: if any `pending` is set, register the selected index into `grant_id`, load `tx_din <= hold[sel]`, and go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: `tx_start = 1` for exactly this cycle. Clear the watchdog counter. Go to WAIT.
  - WAIT: `tx_din` is held.
    - If `tx_done` is high, go to RELEASE and flag normal completion.
    - Otherwise, if `tmo_limit != 0` and `cnt == tmo_limit-1`, go to RELEASE and flag timeout.
    - Otherwise increment `cnt`.
  - RELEASE: clear `pending[grant_id]`, set `last_grant = grant_id`, pulse `sent` or `tmo_err`, then go to IDLE.
  - Illegal encodings go to IDLE with `pending` unchanged.
- `tx_done` is ignored in every state except WAIT.
  - This covers the transmitter's post-reset done pulse.
- `tx_done` and the timeout condition in the same cycle: `tx_done` wins, so `sent` pulses and `tmo_err` does not.
- On timeout the byte is dropped: `pending` clears and the requester may reload.
- `tmo_limit` is sampled live every WAIT cycle.
- `tx_din`: loaded only on the IDLE→LAUNCH transition. Otherwise it keeps its last value, even in IDLE, because the transmitter samples `Tx_din` throughout its frame.
- Reset values, applied on `rst_n` low at any time including mid-frame:
  - State IDLE.
  - `pending` all 0, `req_ready` all 1.
  - `tx_start` 0, `tx_din` 0, `grant_id` 0, `busy` 0, `sent` 0, `tmo_err` 0, `cnt` 0.
  - An in-flight byte is discarded.

## Timing
- All outputs are registered or decoded directly from state flops.
- Normal sequence:
  - Handshake accepted in cycle 0.
  - IDLE selects in cycle 1.
  - `tx_start` is high in cycle 2 (LAUNCH), with `tx_din` already valid in cycle 2.
  - WAIT starts in cycle 3.
- Release sequence:
  - `tx_done` seen in cycle k.
  - RELEASE and the `sent` pulse occur in cycle k+1.
  - IDLE in cycle k+2, with `req_ready[grant]` high again.
  - The next LAUNCH comes at cycle k+3 at the earliest.
- Back-to-back frames have a 3-cycle gap from `tx_done` to the next `tx_start`.
- Timeout: `tmo_err` pulses in cycle 3+`tmo_limit` relative to cycle 0, when `tx_done` never arrives.
- `busy` is high from LAUNCH through RELEASE inclusive.

## Test plan
- Single byte: reset, `req_valid[2]`=1 with 0xA5 in cycle 0. Expect `req_ready[2]`=0 from cycle 1, `tx_start` pulse in cycle 2, `tx_din`=0xA5, and `grant_id`=2. Model `tx_done` at cycle 50 → `sent` at 51, `req_ready[2]`=1 at 52.
- Fairness: all four requesters loaded with 0x10..0x13 simultaneously. Expect grant order 0,1,2,3. Then reload 0 and 3 while 1 is active → next grants are 2, 3, 0.
- Stability: a slow transmitter model checks `tx_din` unchanged from LAUNCH through `tx_done` while `req_data` toggles every cycle. Expect no extra `tx_start` pulses.
- Watchdog: `tmo_limit`=20, `tx_done` never asserted. Expect `tmo_err` exactly 20 cycles after `tx_start` +1, `pending` cleared, and the next requester launched. Also check `tx_done` on the limit cycle → `sent`=1, `tmo_err`=0, and `tmo_limit`=0 → waits indefinitely.
- Spurious done and reset: pulse `tx_done` in IDLE → no effect. Assert `rst_n`=0 during WAIT → all outputs at reset values, and `req_ready`=all 1 after release.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte
// producers. Each requester parks one byte in a private holding register;
// the arbiter launches the transmitter for one pending byte at a time, holds
// the byte stable for the whole frame and releases on done or on watchdog
// expiry.
module uart_tx_arbiter #(
    parameter  int N_REQ  = 4,
    parameter  int W_DATA = 8,
    parameter  int W_TMO  = 24,
    localparam int W_ID   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*W_DATA-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [W_TMO-1:0]          tmo_limit,
    output logic                      tx_start,
    output logic [W_DATA-1:0]         tx_din,
    input  logic                      tx_done,
    output logic [W_ID-1:0]           grant_id,
    output logic                      busy,
    output logic                      sent,
    output logic                      tmo_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [W_ID-1:0]     grant_id_q, grant_id_d;
    logic [W_ID-1:0]     last_grant_q, last_grant_d;
    logic [W_DATA-1:0]   tx_din_q, tx_din_d;
    logic [W_TMO-1:0]    cnt_q, cnt_d;
    logic                tx_start_q, tx_start_d;
    logic                sent_q, sent_d;
    logic                tmo_err_q, tmo_err_d;
    logic [N_REQ-1:0]    pending_q, pending_d;
    logic [W_DATA-1:0]   hold_q [N_REQ];
    logic [W_DATA-1:0]   hold_d [N_REQ];

    logic [W_ID-1:0]     sel_s;
    logic                sel_found_s;
    logic                tmo_hit_s;

    // Round-robin pick: first pending index after the last grant, wrapping.
    always_comb begin
        int unsigned idx_s;
        idx_s       = 0;
        sel_s       = '0;
        sel_found_s = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx_s = (int'(last_grant_q) + k) % N_REQ;
            if (!sel_found_s && pending_q[W_ID'(idx_s)]) begin
                sel_found_s = 1'b1;
                sel_s       = W_ID'(idx_s);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Holding registers: capture on handshake, drop the granted slot on release.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                hold_d[i]    = req_data[i*W_DATA +: W_DATA];
            end else begin
                hold_d[i]    = hold_q[i];
            end
        end
        if (state_q == ST_RELEASE) begin
            pending_d[grant_id_q] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
    end

    // Watchdog expiry: only armed when the limit is non-zero, limit read live.
    always_comb begin
        if (tmo_limit != '0) begin
            tmo_hit_s = (cnt_q == (tmo_limit - W_TMO'(1'b1)));
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Grant FSM next-state and registered-output staging.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        tx_din_d     = tx_din_q;
        cnt_d        = cnt_q;
        tx_start_d   = 1'b0;
        sent_d       = 1'b0;
        tmo_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found_s) begin
                    state_d    = ST_LAUNCH;
                    grant_id_d = sel_s;
                    tx_din_d   = hold_q[sel_s];
                    tx_start_d = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done beats a simultaneous watchdog expiry
                if (tx_done) begin
                    state_d = ST_RELEASE;
                    sent_d  = 1'b1;
                end else if (tmo_hit_s) begin
                    state_d   = ST_RELEASE;
                    tmo_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + W_TMO'(1'b1);
                end
            end
            ST_RELEASE: begin
                last_grant_d = grant_id_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= W_ID'(N_REQ - 1);
            tx_din_q     <= '0;
            cnt_q        <= '0;
            tx_start_q   <= 1'b0;
            sent_q       <= 1'b0;
            tmo_err_q    <= 1'b0;
            pending_q    <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            tx_din_q     <= tx_din_d;
            cnt_q        <= cnt_d;
            tx_start_q   <= tx_start_d;
            sent_q       <= sent_d;
            tmo_err_q    <= tmo_err_d;
            pending_q    <= pending_d;
            for (int i = 0; i < N_REQ; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign req_ready = ~pending_q;
    assign busy      = (state_q != ST_IDLE);
    assign tx_start  = tx_start_q;
    assign tx_din    = tx_din_q;
    assign grant_id  = grant_id_q;
    assign sent      = sent_q;
    assign tmo_err   = tmo_err_q;

endmodule
